// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for a reduced RV32 core (ADDI, ADD, BNE).
// Owns the PC, fetches over a req/valid handshake, and drives every datapath control.
module control_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     EQ,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     retire,
    output logic                     illegal
);

    // Handshake: in FETCH imem_req stays high with imem_addr=pc until a cycle
    // where imem_valid is high; imem_rdata is captured on that same edge.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]              ir_q, ir_d;
    logic                     illegal_q, illegal_d;
    logic                     eq_q, eq_d;

    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic                     is_addi, is_add, is_bne;
    logic                     decoded_active;
    logic [ADDRESS_WIDTH-1:0] imm_addr;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);

    // Branch offset is sign-extended to the address width before the PC add.
    assign imm_addr  = ADDRESS_WIDTH'($signed(ImmOp));
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign illegal   = illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[ADDRESS_WIDTH-1:0];
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            eq_q      <= eq_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        illegal_d      = illegal_q;
        eq_d           = eq_q;
        imem_req       = 1'b0;
        RegWrite       = 1'b0;
        retire         = 1'b0;
        decoded_active = 1'b0;
        rs1            = 5'd0;
        rs2            = 5'd0;
        rd             = 5'd0;
        ALUsrc         = 1'b0;
        ALUctrl        = 3'b000;
        ImmOp          = '0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata[31:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decoded_active = 1'b1;
                if (is_addi || is_add || is_bne) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                decoded_active = 1'b1;
                eq_d           = EQ;
                state_d        = S_WB;
            end
            S_WB: begin
                decoded_active = 1'b1;
                retire         = 1'b1;
                RegWrite       = (is_addi || is_add) && (ir_q[11:7] != 5'd0);
                state_d        = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (decoded_active) begin
            rs1 = ir_q[19:15];
            rs2 = ir_q[24:20];
            rd  = ir_q[11:7];
            if (is_addi) begin
                ALUsrc = 1'b1;
                ImmOp  = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
            end else if (is_bne) begin
                ALUctrl = 3'b001;
                ImmOp   = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7],
                           ir_q[30:25], ir_q[11:8], 1'b0};
            end
        end

        // PC update needs ImmOp, so it follows the decode block.
        if (state_q == S_WB) begin
            if (is_bne && !eq_q) pc_d = pc_q + imm_addr;
            else                 pc_d = pc_q + ADDRESS_WIDTH'(4);
        end

        if (rst) begin
            imem_req = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer; expected values come from
// an instruction-level model that decodes fields with plain integer arithmetic.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUsrc;
  logic [2:0]  ALUctrl;
  logic [31:0] ImmOp;
  logic        EQ;
  logic [31:0] pc;
  logic        retire, illegal;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp),
    .EQ(EQ), .pc(pc), .retire(retire), .illegal(illegal)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 ADDI, 1 ADD, 2 BNE, 3 unsupported
  function automatic int model_kind(input logic [31:0] ins);
    int opc, f3, f7;
    opc = int'(ins % 128);
    f3  = int'((ins / 4096) % 8);
    f7  = int'(ins / 33554432);
    if (opc == 19 && f3 == 0) return 0;
    if (opc == 51 && f3 == 0 && f7 == 0) return 1;
    if (opc == 99 && f3 == 1) return 2;
    return 3;
  endfunction

  function automatic int model_imm(input logic [31:0] ins, input int kind);
    int v;
    if (kind == 0) begin
      v = int'(ins / 1048576);
      if (v >= 2048) v -= 4096;
      return v;
    end
    if (kind == 2) begin
      v = int'((ins / 256) % 16) * 2 + int'((ins / 33554432) % 64) * 32
        + int'((ins / 128) % 2) * 2048 - int'(ins / 32'h8000_0000) * 4096;
      return v;
    end
    return 0;
  endfunction

  function automatic logic [31:0] field5(input logic [31:0] ins, input int lsb);
    return (ins >> lsb) % 32;
  endfunction

  task automatic chk_idle_ctrl(input string tag);
    chk({tag, "_rs1"}, {27'd0, rs1}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
    chk({tag, "_alusrc"}, {31'd0, ALUsrc}, 32'd0);
    chk({tag, "_immop"}, ImmOp, 32'd0);
    chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
  endtask

  task automatic chk_decoded(input string tag, input logic [31:0] ins);
    int k;
    int imm;
    k   = model_kind(ins);
    imm = model_imm(ins, k);
    chk({tag, "_rs1"}, {27'd0, rs1}, field5(ins, 15));
    chk({tag, "_rs2"}, {27'd0, rs2}, field5(ins, 20));
    chk({tag, "_rd"}, {27'd0, rd}, field5(ins, 7));
    chk({tag, "_alusrc"}, {31'd0, ALUsrc}, (k == 0) ? 32'd1 : 32'd0);
    chk({tag, "_aluctrl"}, {29'd0, ALUctrl}, (k == 2) ? 32'd1 : 32'd0);
    chk({tag, "_immop"}, ImmOp, 32'(imm));
    chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 back in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int stalls, input logic eq);
    int          k;
    logic [31:0] nxt;
    k = model_kind(ins);
    nxt = (k == 2 && !eq) ? exp_pc + 32'(model_imm(ins, k)) : exp_pc + 32'd4;
    exp_q.push_back(nxt);
    for (int s = 0; s < stalls; s++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, exp_pc);
      chk_idle_ctrl("stall");
      next_cycle();
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk_idle_ctrl("fetch");
    next_cycle();
    imem_valid = 1'($urandom);
    imem_rdata = $urandom;
    @(negedge clk);
    chk_decoded("decode", ins);
    next_cycle();
    EQ = eq;
    imem_valid = 1'($urandom);
    @(negedge clk);
    chk_decoded("exec", ins);
    chk("exec_retire", {31'd0, retire}, 32'd0);
    next_cycle();
    EQ = 1'($urandom);
    imem_valid = 1'($urandom);
    @(negedge clk);
    chk("wb_regwrite", {31'd0, RegWrite},
        ((k == 0 || k == 1) && field5(ins, 7) != 0) ? 32'd1 : 32'd0);
    chk("wb_retire", {31'd0, retire}, 32'd1);
    chk("wb_pc", pc, exp_pc);
    next_cycle();
    imem_valid = 1'b0;
    exp_pc = exp_q.pop_front();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    imem_valid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
    end
    chk("rst_pc", pc, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    next_cycle();
    rst = 1'b0;
    exp_pc = 32'd0;
  endtask

  function automatic logic [31:0] enc_addi(input int imm, input int r1, input int rdst);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(r1), 3'b000, 5'(rdst), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input int r1, input int r2, input int rdst);
    return {7'b0, 5'(r2), 5'(r1), 3'b000, 5'(rdst), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_bne(input int off, input int r1, input int r2);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'(r2), 5'(r1), 3'b001, b[4:1], b[11], 7'b1100011};
  endfunction

  initial begin
    rst = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    EQ = 1'b0;
    exp_pc = 32'd0;

    // Reset and basic program from pc=0
    do_reset(2);
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);
    next_cycle();
    run_instr(32'h0050_0093, 0, 1'b0);
    run_instr(32'h0020_81B3, 0, 1'b0);
    run_instr(32'hFE00_9CE3, 0, 1'b0);
    chk("bne_taken_pc", exp_pc, 32'd0);
    run_instr(32'h0020_8033, 0, 1'b0);
    run_instr(32'h0050_0093, 0, 1'b0);
    run_instr(32'hFE00_9CE3, 0, 1'b1);
    run_instr(32'h0050_0093, 3, 1'b0);

    // Negative branch from pc=0 wraps, then +4 wraps back to 0
    do_reset(1);
    run_instr(32'hFE00_9CE3, 0, 1'b0);
    run_instr(32'h0050_0093, 0, 1'b0);
    run_instr(32'h0050_0093, 0, 1'b0);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'd0);
    next_cycle();

    // Randomized instruction stream with random stalls, EQ and immediates
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      case ($urandom_range(0, 2))
        0: ins = enc_addi(int'($urandom_range(0, 4095)) - 2048,
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        1: ins = enc_add(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)));
        default: ins = enc_bne((int'($urandom_range(0, 4095)) - 2048) * 2,
                               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      endcase
      run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Unsupported instruction halts until reset
    do_reset(1);
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0000;
    next_cycle();
    imem_valid = 1'b0;
    @(negedge clk);
    chk("ill_decode_flag", {31'd0, illegal}, 32'd0);
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      imem_valid = 1'($urandom);
      imem_rdata = 32'h0050_0093;
      @(negedge clk);
      chk("halt_illegal", {31'd0, illegal}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_retire", {31'd0, retire}, 32'd0);
      chk_idle_ctrl("halt");
      next_cycle();
    end
    do_reset(1);
    @(negedge clk);
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    chk("unhalt_addr", imem_addr, 32'd0);
    next_cycle();

    // Reset during EXEC abandons the ADDI
    run_instr(32'h0050_0093, 0, 1'b0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    next_cycle();
    imem_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_exec_retire", {31'd0, retire}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_exec_regwrite2", {31'd0, RegWrite}, 32'd0);
    chk("rst_exec_pc", pc, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_req", {31'd0, imem_req}, 32'd1);
    chk("rst_exec_addr", imem_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle fetch/decode/control sequencer that generates every datapath control the reduced RISC-V CPU consumes. Outputs: register addresses rs1/rs2/rd, RegWrite, ALUsrc, ALUctrl, ImmOp. It consumes the ALU's EQ flag to resolve branches. It owns the PC and fetches instructions over a req/valid instruction-memory handshake. Supported instructions: ADDI, ADD, BNE. Anything else traps to a sticky halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDRESS_WIDTH, 32, PC / instruction-memory address width
DATA_WIDTH, 32, instruction and ImmOp width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request
imem_addr  out  ADDRESS_WIDTH  fetch address (= pc)
imem_valid  in  1  imem_rdata valid this cycle
imem_rdata  in  DATA_WIDTH  fetched instruction
rs1  out  5  register-file read address 1 (IR[19:15])
rs2  out  5  register-file read address 2 (IR[24:20])
rd  out  5  register-file write address (IR[11:7])
RegWrite  out  1  register-file write enable
ALUsrc  out  1  0 = ALU operand 2 from register, 1 = from ImmOp
ALUctrl  out  3  000 = add, 001 = sub
ImmOp  out  DATA_WIDTH  sign-extended immediate
EQ  in  1  ALU equality flag (ALUop1 == ALUop2)
pc  out  ADDRESS_WIDTH  current PC
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  sticky unsupported-instruction flag

Behaviour:
- States: FETCH, DECODE, EXEC, WB, HALT. Registers: pc, 32-bit IR, state, illegal.
- Reset (rising edge with rst=1): state=FETCH, pc=RESET_PC, IR=0, illegal=0.
  - While rst=1: imem_req=0, RegWrite=0, retire=0.
  - rst at any state, mid-stall included, abandons the in-flight instruction. No write or PC update occurs for it.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=0: hold state; imem_req and imem_addr stay stable.
  - imem_valid=1 (same-cycle response allowed): IR<=imem_rdata, go to DECODE.
  - imem_valid outside FETCH is ignored.
- DECODE: decode IR.
  - opcode 0010011 with funct3 000 is ADDI.
  - opcode 0110011 with funct3 000 and funct7 0000000 is ADD.
  - opcode 1100011 with funct3 001 is BNE.
  - Supported: go to EXEC. Otherwise: illegal<=1, go to HALT.
- Decoded outputs are combinational from IR. They are valid in DECODE, EXEC and WB; 0 in FETCH and HALT.
  - ADDI: ALUsrc=1, ALUctrl=000, ImmOp = sign-extended IR[31:20].
  - ADD: ALUsrc=0, ALUctrl=000, ImmOp=0.
  - BNE: ALUsrc=0, ALUctrl=001, ImmOp = sign-extended {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
- EXEC: one settle cycle. For BNE, EQ is sampled and registered at the end of EXEC. Go to WB.
- WB:
  - RegWrite=1 for ADDI/ADD with rd!=0; RegWrite=0 for rd==0 and for BNE.
  - retire=1.
  - pc <= pc+ImmOp if BNE and registered EQ=0; otherwise pc <= pc+4.
  - Go to FETCH.
- PC arithmetic is modulo 2^ADDRESS_WIDTH; wrap-around is silent.
- HALT: all control outputs 0, imem_req=0, illegal=1. Only rst exits HALT.
- Latency: 4 cycles per instruction with a zero-wait memory; plus N cycles for N stall cycles.

Test Plan:
1. Reset: rst high 2 cycles -> pc=0, imem_req=0, RegWrite=0, illegal=0. First cycle after release: imem_req=1, imem_addr=0.
2. ADDI x1,x0,5 (0x00500093), valid same cycle -> DECODE: rs1=0, rd=1, ImmOp=5, ALUsrc=1, ALUctrl=000. WB: RegWrite=1, retire=1. Next FETCH: imem_addr=4.
3. ADD x3,x1,x2 (0x002081B3) -> rs1=1, rs2=2, rd=3, ALUsrc=0, RegWrite=1 in WB. The same instruction with rd=0 (0x00208033) -> RegWrite=0, retire=1.
4. BNE x1,x0,-8 (0xFE009CE3) at pc=8 -> ImmOp=0xFFFFFFF8, ALUctrl=001. EQ=0 in EXEC: next imem_addr=0. EQ=1: next imem_addr=12. RegWrite=0 in both cases.
5. Stall: imem_valid low 3 cycles in FETCH -> imem_req=1 and imem_addr constant; decoded outputs and RegWrite stay 0. Valid on cycle 4 -> DECODE on the next cycle.
6. Illegal 0x00000000 -> illegal=1 after DECODE; imem_req stays 0 and RegWrite stays 0 for 20 cycles; rst clears illegal and restarts at pc=0. Separately, rst asserted in EXEC of an ADDI -> no RegWrite, pc=0 after reset.
